// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and default width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/mult_add_stage.sv
// One shift-add iteration: gate the multiplicand by the LSB mask, add it to the upper
// accumulator with carry, and shift the whole product register right by one.
module mult_add_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [WIDTH-2:0]   low_bits,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mask,
    output logic [2*WIDTH-1:0] next_prod
);

    logic [WIDTH:0] sum;

    // The carry-out lands in the MSB of the product after the shift, so it is never lost.
    assign sum       = {1'b0, acc} + {1'b0, mcand & mask};
    assign next_prod = {sum, low_bits};

endmodule

// File: rtl/sign_extend.sv
// Bit-replicate stage: widens a single bit into a WIDTH-bit all-zeros or all-ones mask.
module sign_extend #(
    parameter int WIDTH = 32
) (
    input  logic             bit_in,
    output logic [WIDTH-1:0] mask
);

    assign mask = {WIDTH{bit_in}};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier: WIDTH iterations produce a 2*WIDTH-bit product,
// followed by a one-cycle done pulse.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]           state;
    logic [CNT_W-1:0]     count;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mask;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   next_prod;

    sign_extend #(
        .WIDTH (WIDTH)
    ) u_lsb_mask (
        .bit_in (prod[0]),
        .mask   (mask)
    );

    mult_add_stage #(
        .WIDTH (WIDTH)
    ) u_add_stage (
        .acc       (prod[2*WIDTH-1:WIDTH]),
        .low_bits  (prod[WIDTH-1:1]),
        .mcand     (mcand),
        .mask      (mask),
        .next_prod (next_prod)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
            mcand <= '0;
            prod  <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    prod  <= next_prod;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new start; DONE otherwise falls back to IDLE.
                    if (start) begin
                        mcand <= a;
                        prod  <= {{WIDTH{1'b0}}, b};
                        count <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);
    assign product = prod;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier: reset abort, basic, carry, zero,
// ignored start, and back-to-back operation.
module tb_seq_multiplier;

    localparam int WIDTH = 32;

    logic               clk;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int tests_run;
    int tests_failed;

    seq_multiplier #(
        .WIDTH (WIDTH),
        .CNT_W (6)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge, so the next rising edge samples them.
    task automatic do_start(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the falling edge right after start was accepted. Checks 32 busy cycles,
    // optionally pulses a start at cycle pulse_at, then checks the done cycle and stays there.
    task automatic run_op(input string tag, input logic [63:0] exp_prod, input int pulse_at,
                          input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb);
        int busy_bad;
        busy_bad = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
            if (i == pulse_at) begin
                a     = pa;
                b     = pb;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy_cycles_bad"}, 64'(busy_bad), 64'd0);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
        check({tag, " product"}, product, exp_prod);
    endtask

    // Counts done pulses over a window; used to prove no extra done appears.
    task automatic count_done(input string tag, input int cycles, input int exp_pulses);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check({tag, " done_pulses"}, 64'(pulses), 64'(exp_pulses));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state
        #1;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset product", product, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-RUN aborts immediately, no done follows
        do_start(32'd5, 32'd7);
        repeat (9) @(negedge clk);
        check("abort busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort product", product, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        count_done("abort", 40, 0);
        check("abort product_hold", product, 64'd0);

        // Basic 6*7, done lasts one cycle, product holds in IDLE
        do_start(32'd6, 32'd7);
        run_op("basic", 64'd42, -1, '0, '0);
        @(negedge clk);
        check("basic done_one_cycle", {63'd0, done}, 64'd0);
        repeat (3) @(negedge clk);
        check("basic idle_hold", product, 64'd42);

        // Max operands exercise the carry path
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("max", 64'hFFFF_FFFE_0000_0001, -1, '0, '0);

        // Zero multiplicand, same latency
        do_start(32'd0, 32'h1234_5678);
        run_op("zero", 64'd0, -1, '0, '0);

        // Other operands, mixed bits
        do_start(32'h8000_0001, 32'd3);
        run_op("mixed", 64'h1_8000_0003, -1, '0, '0);

        // Start while busy is ignored
        do_start(32'd3, 32'd4);
        run_op("ignore", 64'd12, 4, 32'd9, 32'd9);
        count_done("ignore", 40, 0);
        check("ignore product_hold", product, 64'd12);

        // Back-to-back: start in the done cycle
        do_start(32'd2, 32'd3);
        run_op("b2b_first", 64'd6, -1, '0, '0);
        a     = 32'd10;
        b     = 32'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy_next", {63'd0, busy}, 64'd1);
        run_op("b2b_second", 64'd100, -1, '0, '0);
        count_done("b2b", 5, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Sequential unsigned shift-add multiplier for the MIPS ALU datapath; computes a 2*WIDTH-bit product from two WIDTH-bit operands over WIDTH iterations.
- Sits downstream of the bit-replicate stage (sign_extend).
  - sign_extend widens the current multiplier LSB into a WIDTH-bit mask.
  - This block consumes that mask to gate the multiplicand into its accumulator.
- Feeds the HI/LO result registers of the ALU.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request pulse; sampled on a rising edge of clk.
- a  input  WIDTH  multiplicand; sampled only when start is accepted.
- b  input  WIDTH  multiplier; sampled only when start is accepted.
- busy  output  1  high while an iteration is in progress.
- done  output  1  one-cycle pulse indicating the product is valid.
- product  output  2*WIDTH  result; holds its value until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, counter=0, multiplicand register=0, product register=0.
  - busy=0, done=0.
  - Reset asserted mid-operation aborts the multiply; no done is produced.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Start acceptance (IDLE or DONE with start=1):
  - Latch mcand<=a and prod<={WIDTH'b0, b}; set counter=0; go to RUN.
  - Start in DONE is accepted, giving back-to-back operation. The old product is still visible during that DONE cycle.
  - Start while in RUN is ignored; the operands are not re-sampled.
- RUN iteration (one per clock):
  - mask = sign_extend(prod[0]), i.e. WIDTH copies of the multiplier LSB.
  - sum = {1'b0, prod[2W-1:W]} + {1'b0, mcand & mask}, a (WIDTH+1)-bit sum.
  - prod <= {sum, prod[W-1:1]}, a right shift that keeps the carry-out.
  - counter <= counter+1.
  - When counter==WIDTH-1 at the edge, go to DONE after that edge.
- Latency:
  - If start is sampled at edge k, RUN covers edges k+1..k+WIDTH.
  - done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after start.
- In IDLE without start, the product register and output hold their value.
- Arithmetic:
  - Unsigned only; the full 2W-bit product never overflows.
  - The carry must be retained every iteration; dropping it is a defect.
- Operand corner cases:
  - a=0 or b=0 gives product 0 with the same fixed latency. There is no early termination.

Decomposition:
- Shared package (mult_pkg):
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default WIDTH=32.
- Sub-modules:
  - Reuse the existing sign_extend as the LSB-mask generator; instantiate it once.
  - One natural new sub-module, mult_add_stage: combinational; mask AND, (WIDTH+1)-bit add and shift. It keeps the FSM/counter logic separate from the datapath.

Test Plan:
- Reset mid-RUN: start a=5,b=7, assert reset at cycle 10 -> busy=0, done=0, product=0 immediately; no done pulse follows.
- Basic: a=6,b=7, start one cycle -> busy high 32 cycles, done for exactly one cycle at cycle 33, product=42.
- Max operands: a=b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001 (checks the carry path).
- Zero operand: a=0,b=32'h12345678 -> product=0 at cycle 33; the latency matches the basic case.
- Start ignored while busy: a=3,b=4 start; at cycle 5 pulse start with a=9,b=9 -> product=12; no second done.
- Back-to-back: start a=2,b=3; assert start with a=10,b=10 during the done cycle -> first product=6 visible during done, then busy next cycle, second done 33 cycles later with product=100.
